// File: rtl/y86_writeback.sv
// Y86 write-back stage: W pipeline register, register-file write enables,
// processor status tracking (run/halt/error) and retired-instruction counter.
// Ports:
//   clk, reset (async active-low)
//   Win_*   : instruction arriving from the memory stage
//   W_stall : hold W register; W_bubble : load a bubble into W
//   Wout_*  : W register contents (also the decode forwarding taps)
//   wb_weE, wb_weM : regfile E/M port write enables (combinational from W)
//   cpu_stat, halted : processor status
//   retired_cnt     : saturating retired-instruction count
module y86_writeback #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        Win_stat,
  input  logic [3:0]        Win_icode,
  input  logic              Win_Cnd,
  input  logic [WORD_W-1:0] Win_valE,
  input  logic [WORD_W-1:0] Win_valM,
  input  logic [3:0]        Win_dstE,
  input  logic [3:0]        Win_dstM,
  input  logic              W_stall,
  input  logic              W_bubble,
  output logic [2:0]        Wout_stat,
  output logic [3:0]        Wout_icode,
  output logic              Wout_Cnd,
  output logic [WORD_W-1:0] Wout_valE,
  output logic [WORD_W-1:0] Wout_valM,
  output logic [3:0]        Wout_dstE,
  output logic [3:0]        Wout_dstM,
  output logic              wb_weE,
  output logic              wb_weM,
  output logic [2:0]        cpu_stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HALT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0] state, state_next;
  logic [2:0] err_stat, err_stat_next;
  logic       w_valid;
  logic       raw_we_e, raw_we_m;
  logic       retire;

  // W pipeline register; frozen once the processor leaves RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Wout_stat  <= STAT_AOK;
      Wout_icode <= I_NOP;
      Wout_Cnd   <= 1'b0;
      Wout_valE  <= '0;
      Wout_valM  <= '0;
      Wout_dstE  <= R_NONE;
      Wout_dstM  <= R_NONE;
      w_valid    <= 1'b0;
    end else if (state == S_RUN && !W_stall) begin
      if (W_bubble) begin
        Wout_stat  <= STAT_AOK;
        Wout_icode <= I_NOP;
        Wout_Cnd   <= 1'b0;
        Wout_valE  <= '0;
        Wout_valM  <= '0;
        Wout_dstE  <= R_NONE;
        Wout_dstM  <= R_NONE;
        w_valid    <= 1'b0;
      end else begin
        Wout_stat  <= Win_stat;
        Wout_icode <= Win_icode;
        Wout_Cnd   <= Win_Cnd;
        Wout_valE  <= Win_valE;
        Wout_valM  <= Win_valM;
        Wout_dstE  <= Win_dstE;
        Wout_dstM  <= Win_dstM;
        w_valid    <= 1'b1;
      end
    end
  end

  // Status FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_RUN;
      err_stat <= STAT_AOK;
    end else begin
      state    <= state_next;
      err_stat <= err_stat_next;
    end
  end

  // Status FSM next state: HALT and ERR are sticky until reset
  always_comb begin
    state_next    = state;
    err_stat_next = err_stat;
    case (state)
      S_RUN: begin
        if (Wout_stat == STAT_HLT) begin
          state_next = S_HALT;
        end else if (Wout_stat == STAT_ADR || Wout_stat == STAT_INS) begin
          state_next    = S_ERR;
          err_stat_next = Wout_stat;
        end
      end
      default: ;
    endcase
  end

  // Status outputs
  always_comb begin
    cpu_stat = STAT_AOK;
    halted   = (state != S_RUN);
    case (state)
      S_HALT:  cpu_stat = STAT_HLT;
      S_ERR:   cpu_stat = err_stat;
      default: cpu_stat = STAT_AOK;
    endcase
  end

  // Write enables; popl %esp (same dst on both ports) lets the M write win
  always_comb begin
    raw_we_e = 1'b0;
    raw_we_m = 1'b0;
    case (Wout_icode)
      I_IRMOVL, I_OPL, I_PUSHL, I_CALL, I_RET: raw_we_e = 1'b1;
      I_CMOVXX: raw_we_e = Wout_Cnd;
      I_MRMOVL: raw_we_m = 1'b1;
      I_POPL: begin
        raw_we_e = 1'b1;
        raw_we_m = 1'b1;
      end
      default: ;
    endcase
    wb_weM = raw_we_m && (state == S_RUN) && (Wout_stat == STAT_AOK) &&
             (Wout_dstM != R_NONE);
    wb_weE = raw_we_e && (state == S_RUN) && (Wout_stat == STAT_AOK) &&
             (Wout_dstE != R_NONE) &&
             !(raw_we_m && (Wout_dstE == Wout_dstM));
  end

  // An instruction retires when it leaves a running W stage unstalled
  assign retire = (state == S_RUN) && w_valid && (Wout_stat == STAT_AOK) &&
                  !W_stall && (Wout_icode != I_HALT);

  // Saturating retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
    end else if (retire && (retired_cnt != {CNT_W{1'b1}})) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_y86_writeback.sv
// Self-checking bench for y86_writeback: table of single-cycle vectors plus
// directed sequences for stall, halt/error, async reset and counter saturation.
module tb_y86_writeback;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [3:0] RN  = 4'hF;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        Win_stat;
  logic [3:0]        Win_icode;
  logic              Win_Cnd;
  logic [WORD_W-1:0] Win_valE;
  logic [WORD_W-1:0] Win_valM;
  logic [3:0]        Win_dstE;
  logic [3:0]        Win_dstM;
  logic              W_stall;
  logic              W_bubble;
  logic [2:0]        Wout_stat;
  logic [3:0]        Wout_icode;
  logic              Wout_Cnd;
  logic [WORD_W-1:0] Wout_valE;
  logic [WORD_W-1:0] Wout_valM;
  logic [3:0]        Wout_dstE;
  logic [3:0]        Wout_dstM;
  logic              wb_weE;
  logic              wb_weM;
  logic [2:0]        cpu_stat;
  logic              halted;
  logic [CNT_W-1:0]  retired_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  y86_writeback #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .Win_stat(Win_stat), .Win_icode(Win_icode), .Win_Cnd(Win_Cnd),
    .Win_valE(Win_valE), .Win_valM(Win_valM),
    .Win_dstE(Win_dstE), .Win_dstM(Win_dstM),
    .W_stall(W_stall), .W_bubble(W_bubble),
    .Wout_stat(Wout_stat), .Wout_icode(Wout_icode), .Wout_Cnd(Wout_Cnd),
    .Wout_valE(Wout_valE), .Wout_valM(Wout_valM),
    .Wout_dstE(Wout_dstE), .Wout_dstM(Wout_dstM),
    .wb_weE(wb_weE), .wb_weM(wb_weM),
    .cpu_stat(cpu_stat), .halted(halted), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [31:0] val_e;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        bubble;
    logic        exp_we_e;
    logic        exp_we_m;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic cnd,
                       input logic [31:0] ve, input logic [31:0] vm,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic stall, input logic bubble);
    Win_stat  = st;
    Win_icode = ic;
    Win_Cnd   = cnd;
    Win_valE  = ve;
    Win_valM  = vm;
    Win_dstE  = de;
    Win_dstM  = dm;
    W_stall   = stall;
    W_bubble  = bubble;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] ev;
    logic [3:0]  ed;

    reset = 1'b0;
    drive(AOK, 4'h1, 1'b0, 32'h0, 32'h0, RN, RN, 1'b0, 1'b0);

    //                stat icode cnd  valE         dstE  dstM bub  weE   weM   cnt
    vecs[0] = '{AOK, 4'h3, 1'b0, 32'h1234,    4'h2, RN,  1'b0, 1'b1, 1'b0, 4'd0};
    vecs[1] = '{AOK, 4'h2, 1'b0, 32'h11,      4'h3, RN,  1'b0, 1'b0, 1'b0, 4'd1};
    vecs[2] = '{AOK, 4'h2, 1'b1, 32'h22,      4'h3, RN,  1'b0, 1'b1, 1'b0, 4'd2};
    vecs[3] = '{AOK, 4'hB, 1'b0, 32'h33,      4'h4, 4'h4, 1'b0, 1'b0, 1'b1, 4'd3};
    vecs[4] = '{AOK, 4'hB, 1'b0, 32'h44,      4'h4, 4'h5, 1'b0, 1'b1, 1'b1, 4'd4};
    vecs[5] = '{AOK, 4'h5, 1'b0, 32'h55,      RN,   4'h6, 1'b0, 1'b0, 1'b1, 4'd5};
    vecs[6] = '{AOK, 4'h6, 1'b0, 32'h66,      RN,   RN,   1'b0, 1'b0, 1'b0, 4'd6};
    vecs[7] = '{AOK, 4'h4, 1'b0, 32'h77,      RN,   RN,   1'b0, 1'b0, 1'b0, 4'd7};
    vecs[8] = '{AOK, 4'h3, 1'b0, 32'h88,      4'h1, RN,   1'b1, 1'b0, 1'b0, 4'd8};
    vecs[9] = '{AOK, 4'h8, 1'b0, 32'h99,      4'h4, RN,   1'b0, 1'b1, 1'b0, 4'd8};

    // Reset state
    #12;
    check("rst_icode", 32'(Wout_icode), 32'h1);
    check("rst_dstE", 32'(Wout_dstE), 32'(RN));
    check("rst_dstM", 32'(Wout_dstM), 32'(RN));
    check("rst_cnt", 32'(retired_cnt), 32'h0);
    check("rst_cpu_stat", 32'(cpu_stat), 32'(AOK));
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_weE", 32'(wb_weE), 32'h0);
    check("rst_weM", 32'(wb_weM), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].stat, vecs[i].icode, vecs[i].cnd, vecs[i].val_e, 32'hA000 + 32'(i),
            vecs[i].dst_e, vecs[i].dst_m, 1'b0, vecs[i].bubble);
      tick();
      ev = vecs[i].bubble ? 32'h0 : vecs[i].val_e;
      ed = vecs[i].bubble ? RN : vecs[i].dst_e;
      check($sformatf("v%0d_icode", i), 32'(Wout_icode),
            vecs[i].bubble ? 32'h1 : 32'(vecs[i].icode));
      check($sformatf("v%0d_valE", i), Wout_valE, ev);
      check($sformatf("v%0d_dstE", i), 32'(Wout_dstE), 32'(ed));
      check($sformatf("v%0d_weE", i), 32'(wb_weE), 32'(vecs[i].exp_we_e));
      check($sformatf("v%0d_weM", i), 32'(wb_weM), 32'(vecs[i].exp_we_m));
      check($sformatf("v%0d_cnt", i), 32'(retired_cnt), 32'(vecs[i].exp_cnt));
    end

    // Stall holds a valid mrmovl; it retires only once stall drops
    do_reset();
    drive(AOK, 4'h5, 1'b0, 32'h0, 32'hABCD, RN, 4'h6, 1'b0, 1'b0);
    tick();
    check("st_load_weM", 32'(wb_weM), 32'h1);
    drive(AOK, 4'h3, 1'b0, 32'h5A5A, 32'h0, 4'h2, RN, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("st%0d_icode", k), 32'(Wout_icode), 32'h5);
      check($sformatf("st%0d_valM", k), Wout_valM, 32'hABCD);
      check($sformatf("st%0d_weM", k), 32'(wb_weM), 32'h1);
      check($sformatf("st%0d_cnt", k), 32'(retired_cnt), 32'h0);
    end
    W_stall = 1'b0;
    tick();
    check("st_rel_cnt", 32'(retired_cnt), 32'h1);
    check("st_rel_icode", 32'(Wout_icode), 32'h3);
    drive(AOK, 4'h6, 1'b0, 32'h1, 32'h0, 4'h7, RN, 1'b1, 1'b1);
    tick();
    check("stbub_icode", 32'(Wout_icode), 32'h3);
    check("stbub_valE", Wout_valE, 32'h5A5A);
    check("stbub_weE", 32'(wb_weE), 32'h1);
    check("stbub_cnt", 32'(retired_cnt), 32'h1);
    drive(AOK, 4'h1, 1'b0, 32'h0, 32'h0, RN, RN, 1'b0, 1'b0);
    tick();
    check("stbub_rel_cnt", 32'(retired_cnt), 32'h2);

    // Halt: no writes while halt sits in W, then sticky HALT with W frozen
    do_reset();
    drive(HLT, 4'h0, 1'b0, 32'h0, 32'h0, RN, RN, 1'b0, 1'b0);
    tick();
    check("hlt_weE", 32'(wb_weE), 32'h0);
    check("hlt_weM", 32'(wb_weM), 32'h0);
    check("hlt_pre_halted", 32'(halted), 32'h0);
    drive(AOK, 4'h3, 1'b0, 32'h55, 32'h0, 4'h2, RN, 1'b0, 1'b0);
    tick();
    check("hlt_cpu_stat", 32'(cpu_stat), 32'(HLT));
    check("hlt_halted", 32'(halted), 32'h1);
    check("hlt_weE_frozen", 32'(wb_weE), 32'h0);
    drive(AOK, 4'h6, 1'b0, 32'h99, 32'h0, 4'h5, RN, 1'b0, 1'b0);
    tick();
    tick();
    check("hlt_W_icode", 32'(Wout_icode), 32'h3);
    check("hlt_W_dstE", 32'(Wout_dstE), 32'h2);
    check("hlt_cnt", 32'(retired_cnt), 32'h0);
    check("hlt_sticky", 32'(cpu_stat), 32'(HLT));

    // Address error after a few retired nops, then async reset mid-cycle
    do_reset();
    drive(AOK, 4'h1, 1'b0, 32'h0, 32'h0, RN, RN, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick();
    drive(ADR, 4'h5, 1'b0, 32'h0, 32'h0, RN, 4'h3, 1'b0, 1'b0);
    tick();
    check("adr_weM", 32'(wb_weM), 32'h0);
    check("adr_pre_stat", 32'(cpu_stat), 32'(AOK));
    drive(AOK, 4'h1, 1'b0, 32'h0, 32'h0, RN, RN, 1'b0, 1'b0);
    tick();
    check("adr_cpu_stat", 32'(cpu_stat), 32'(ADR));
    check("adr_halted", 32'(halted), 32'h1);
    check("adr_cnt", 32'(retired_cnt), 32'h3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_halted", 32'(halted), 32'h0);
    check("arst_cpu_stat", 32'(cpu_stat), 32'(AOK));
    check("arst_cnt", 32'(retired_cnt), 32'h0);
    check("arst_icode", 32'(Wout_icode), 32'h1);
    check("arst_dstM", 32'(Wout_dstM), 32'(RN));
    #1;
    reset = 1'b1;

    // Counter saturation at 2^CNT_W-1
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15 || k == 16 || k == 20)
        check($sformatf("sat_cnt_k%0d", k), 32'(retired_cnt), (k - 1 > 15) ? 32'd15 : 32'(k - 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
